l0_branch_prefetcher: RTL and testbench



---
 rtl/l0_prefetch_pkg.sv | 26 ++
 rtl/fifo_sync.sv | 56 +++++
 rtl/l0_branch_decode.sv | 23 ++
 rtl/l0_branch_prefetcher.sv | 133 +++++++++++++
 tb/tb_l0_branch_prefetcher.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/l0_prefetch_pkg.sv
// Shared decode constants, prefetch entry type and RISC-V immediate helpers
// for the L0 branch-target prefetcher.
package l0_prefetch_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  // Bit n set when funct3 == n is a real conditional branch (BEQ/BNE/BLT/BGE/BLTU/BGEU).
  localparam logic [7:0] BR_F3_VALID = 8'b1111_0011;

  localparam int unsigned PF_ADDR_W = 32;

  typedef struct packed {
    logic [PF_ADDR_W-1:0] addr;
    logic                 is_jal;
  } pf_entry_t;

  // Both immediates are returned at the J-type width so one adder serves both.
  function automatic logic signed [20:0] decode_b_imm(input logic [31:0] i);
    return {{8{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  function automatic logic signed [20:0] decode_j_imm(input logic [31:0] i);
    return {i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// Common synchronous FIFO primitive: registered storage, no fall-through,
// head visible on rdata_o whenever empty_o is low.
module fifo_sync #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push, do_pop;

  assign empty_o = (count == '0);
  assign full_o  = (count == (PTR_W+1)'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is pure data; occupancy alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata_i;
  end

endmodule

// File: rtl/l0_branch_decode.sv
// Combinational slot decoder: flags conditional branches and JAL and
// extracts the matching sign-extended immediate.
module l0_branch_decode
  import l0_prefetch_pkg::*;
(
  input  logic [31:0]        instr,
  output logic               match,
  output logic               is_jal,
  output logic signed [20:0] imm
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic       is_br;

  assign opc    = instr[6:0];
  assign f3     = instr[14:12];
  assign is_br  = (opc == OPC_BRANCH) && BR_F3_VALID[f3];
  assign is_jal = (opc == OPC_JAL);
  assign match  = is_br || is_jal;
  assign imm    = is_jal ? decode_j_imm(instr) : decode_b_imm(instr);

endmodule

// File: rtl/l0_branch_prefetcher.sv
// Scans returned L0 lines one slot per cycle, turns branch/JAL targets into
// line addresses and queues them as prefetch requests for the refill path.
module l0_branch_prefetcher
  import l0_prefetch_pkg::*;
#(
  parameter int unsigned LINE_WIDTH    = 128,
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter bit          EN_BRANCH     = 1'b1,
  parameter bit          EN_JAL        = 1'b1,
  parameter bit          BACKWARD_ONLY = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  line_valid_i,
  output logic                  line_ready_o,
  input  logic [ADDR_WIDTH-1:0] line_addr_i,
  input  logic [LINE_WIDTH-1:0] line_data_i,
  output logic                  pf_valid_o,
  input  logic                  pf_ready_i,
  output logic [ADDR_WIDTH-1:0] pf_addr_o,
  output logic                  pf_is_jal_o,
  output logic                  busy_o
);

  localparam int unsigned NSLOT  = LINE_WIDTH / 32;
  localparam int unsigned SLOT_W = $clog2(NSLOT);
  localparam int unsigned OFF_W  = $clog2(LINE_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {{(ADDR_WIDTH-OFF_W){1'b1}}, {OFF_W{1'b0}}};

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                   state;
  logic [SLOT_W-1:0]        slot;
  logic [ADDR_WIDTH-1:0]    line_addr_q;
  logic [LINE_WIDTH-1:0]    line_data_q;
  logic                     lp_vld;
  logic [ADDR_WIDTH-1:0]    lp_addr;

  logic [31:0]              instr;
  logic                     dec_match, dec_is_jal;
  logic signed [20:0]       dec_imm;
  logic signed [ADDR_WIDTH-1:0] imm_ext;
  logic [ADDR_WIDTH-1:0]    pc, target, tline;
  logic                     type_en, bw_ok, want, push, stall;
  logic                     fifo_empty, fifo_full;
  pf_entry_t                push_e, head;

  assign instr = line_data_q[{slot, 5'b0} +: 32];

  l0_branch_decode u_decode (
    .instr  (instr),
    .match  (dec_match),
    .is_jal (dec_is_jal),
    .imm    (dec_imm)
  );

  assign imm_ext = ADDR_WIDTH'(dec_imm);
  assign pc      = line_addr_q + ADDR_WIDTH'({slot, 2'b00});
  assign target  = pc + $unsigned(imm_ext);
  assign tline   = target & LINE_MASK;

  assign type_en = dec_is_jal ? EN_JAL : EN_BRANCH;
  assign bw_ok   = !BACKWARD_ONLY || dec_is_jal || dec_imm[20];
  // Own-line targets are already resident; back-to-back repeats are redundant.
  assign want    = (state == SCAN) && dec_match && type_en && bw_ok &&
                   (tline != line_addr_q) && !(lp_vld && (tline == lp_addr));
  assign push    = want && !fifo_full;
  assign stall   = want && fifo_full;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      slot   <= '0;
      lp_vld <= 1'b0;
    end else if (flush_i) begin
      state  <= IDLE;
      slot   <= '0;
      lp_vld <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (line_valid_i) begin
            state <= SCAN;
            slot  <= '0;
          end
        end
        SCAN: begin
          if (push) lp_vld <= 1'b1;
          if (!stall) begin
            if (slot == SLOT_W'(NSLOT - 1)) state <= IDLE;
            slot <= slot + SLOT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if ((state == IDLE) && line_valid_i) begin
      line_addr_q <= line_addr_i & LINE_MASK;
      line_data_q <= line_data_i;
    end
    if (push) lp_addr <= tline;
  end

  assign push_e.addr   = PF_ADDR_W'(tline);
  assign push_e.is_jal = dec_is_jal;

  fifo_sync #(
    .WIDTH ($bits(pf_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (push),
    .wdata_i (push_e),
    .pop_i   (pf_valid_o && pf_ready_i),
    .rdata_o (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign line_ready_o = (state == IDLE);
  assign pf_valid_o   = !fifo_empty;
  assign pf_addr_o    = fifo_empty ? '0 : ADDR_WIDTH'(head.addr);
  assign pf_is_jal_o  = !fifo_empty && head.is_jal;
  assign busy_o       = (state == SCAN) || !fifo_empty;

endmodule

// File: tb/tb_l0_branch_prefetcher.sv
// Directed bench: a depth-2 default-enable instance and a JAL-disabled,
// backward-only instance share stimulus; issued requests are logged and checked.
module tb_l0_branch_prefetcher;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         line_valid;
  logic [31:0]  line_addr;
  logic [127:0] line_data;
  logic         pf_ready;

  logic         p_line_ready, p_pf_valid, p_pf_is_jal, p_busy;
  logic [31:0]  p_pf_addr;
  logic         s_line_ready, s_pf_valid, s_pf_is_jal, s_busy;
  logic [31:0]  s_pf_addr;

  int unsigned  cyc = 0;
  int           n_tests = 0;
  int           n_fail = 0;
  logic [32:0]  q0[$];
  logic [32:0]  q1[$];
  int unsigned  q0c[$];
  int unsigned  acc_cyc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  l0_branch_prefetcher #(
    .LINE_WIDTH(128), .ADDR_WIDTH(32), .FIFO_DEPTH(2),
    .EN_BRANCH(1'b1), .EN_JAL(1'b1), .BACKWARD_ONLY(1'b0)
  ) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .line_valid_i(line_valid), .line_ready_o(p_line_ready),
    .line_addr_i(line_addr), .line_data_i(line_data),
    .pf_valid_o(p_pf_valid), .pf_ready_i(pf_ready),
    .pf_addr_o(p_pf_addr), .pf_is_jal_o(p_pf_is_jal), .busy_o(p_busy)
  );

  l0_branch_prefetcher #(
    .LINE_WIDTH(128), .ADDR_WIDTH(32), .FIFO_DEPTH(4),
    .EN_BRANCH(1'b1), .EN_JAL(1'b0), .BACKWARD_ONLY(1'b1)
  ) u_dut_bw (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .line_valid_i(line_valid), .line_ready_o(s_line_ready),
    .line_addr_i(line_addr), .line_data_i(line_data),
    .pf_valid_o(s_pf_valid), .pf_ready_i(pf_ready),
    .pf_addr_o(s_pf_addr), .pf_is_jal_o(s_pf_is_jal), .busy_o(s_busy)
  );

  // Inputs change #1 after posedge, so the negedge sees what the next edge will use.
  always @(negedge clk) begin
    if (rst_n && !flush && pf_ready) begin
      if (p_pf_valid) begin
        q0.push_back({p_pf_is_jal, p_pf_addr});
        q0c.push_back(cyc);
      end
      if (s_pf_valid) q1.push_back({s_pf_is_jal, s_pf_addr});
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_q(input string tag, input logic [32:0] got[$], input int n,
                         input logic [32:0] e0, input logic [32:0] e1,
                         input logic [32:0] e2, input logic [32:0] e3);
    logic [32:0] exp[4];
    exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
    check_eq({tag, ".count"}, 64'(got.size()), 64'(n));
    for (int i = 0; i < n; i++)
      check_eq($sformatf("%s.req%0d", tag, i),
               (i < got.size()) ? 64'(got[i]) : 64'hDEAD_BEEF_DEAD, 64'(exp[i]));
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd0, 5'd0, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd0, 7'b1101111};
  endfunction

  task automatic offer_line(input logic [31:0] addr, input logic [31:0] s0, input logic [31:0] s1,
                            input logic [31:0] s2, input logic [31:0] s3);
    int t = 0;
    while (!(p_line_ready && s_line_ready) && t < 100) begin
      step(1);
      t++;
    end
    if (t >= 100) check_eq("offer_timeout", 1, 0);
    line_addr  = addr;
    line_data  = {s3, s2, s1, s0};
    line_valid = 1'b1;
    acc_cyc    = cyc;
    step(1);
    line_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while ((p_busy || s_busy || !p_line_ready || !s_line_ready) && t < 100) begin
      step(1);
      t++;
    end
    if (t >= 100) check_eq({tag, ".idle_timeout"}, 1, 0);
  endtask

  task automatic clear_logs();
    q0.delete();
    q1.delete();
    q0c.delete();
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; line_valid = 1'b0; pf_ready = 1'b1;
    line_addr = '0; line_data = '0;
    step(3);
    check_eq("rst.line_ready", p_line_ready, 1);
    check_eq("rst.pf_valid",   p_pf_valid,   0);
    check_eq("rst.pf_addr",    p_pf_addr,    0);
    check_eq("rst.pf_is_jal",  p_pf_is_jal,  0);
    check_eq("rst.busy",       p_busy,       0);
    check_eq("rst.bw_busy",    s_busy,       0);
    rst_n = 1'b1;
    step(2);

    // Forward BEQ +0x40 from 0x1004
    clear_logs();
    offer_line(32'h1000, NOP, enc_b(3'b000, 13'h0040), NOP, NOP);
    wait_idle("fwd");
    check_q("fwd", q0, 1, {1'b0, 32'h1040}, '0, '0, '0);
    check_eq("fwd.latency", (q0c.size() > 0) ? 64'(q0c[0] - acc_cyc) : 64'hFFFF, 3);
    check_q("fwd_bw", q1, 0, '0, '0, '0, '0);

    // Backward JAL -0x1000 from 0x200C
    clear_logs();
    offer_line(32'h2000, NOP, NOP, NOP, enc_j(21'h1FF000));
    wait_idle("jal");
    check_q("jal", q0, 1, {1'b1, 32'h1000}, '0, '0, '0);
    check_q("jal_disabled", q1, 0, '0, '0, '0, '0);

    // Target inside the current line
    clear_logs();
    offer_line(32'h3000, enc_b(3'b001, 13'h0004), NOP, NOP, NOP);
    wait_idle("same");
    check_q("same", q0, 0, '0, '0, '0, '0);

    // Two slots hitting line 0x5000
    clear_logs();
    offer_line(32'h4800, enc_b(3'b000, 13'h0800), NOP, enc_b(3'b001, 13'h07F8), NOP);
    wait_idle("dup");
    check_q("dup", q0, 1, {1'b0, 32'h5000}, '0, '0, '0);

    // funct3 010/011 are not branches
    clear_logs();
    offer_line(32'h6000, enc_b(3'b010, 13'h0040), enc_b(3'b011, 13'h0080), NOP, NOP);
    wait_idle("f3");
    check_q("f3", q0, 0, '0, '0, '0, '0);
    check_q("f3_bw", q1, 0, '0, '0, '0, '0);

    // BLT -0x100 from 0x7004 -> 0x6F04, taken by both instances
    clear_logs();
    offer_line(32'h7000, NOP, enc_b(3'b100, 13'h1F00), NOP, NOP);
    wait_idle("back");
    check_q("back", q0, 1, {1'b0, 32'h6F00}, '0, '0, '0);
    check_q("back_bw", q1, 1, {1'b0, 32'h6F00}, '0, '0, '0);

    // Backpressure on the depth-2 instance
    clear_logs();
    pf_ready = 1'b0;
    offer_line(32'h8000, enc_b(3'b000, 13'h0100), enc_b(3'b001, 13'h01FC),
               enc_b(3'b101, 13'h02F8), enc_b(3'b110, 13'h03F4));
    step(10);
    check_eq("bp.line_ready", p_line_ready, 0);
    check_eq("bp.busy", p_busy, 1);
    check_eq("bp.pf_valid", p_pf_valid, 1);
    check_eq("bp.pf_addr_held", p_pf_addr, 32'h8100);
    pf_ready = 1'b1;
    wait_idle("bp");
    check_q("bp", q0, 4, {1'b0, 32'h8100}, {1'b0, 32'h8200}, {1'b0, 32'h8300}, {1'b0, 32'h8400});
    check_eq("bp.line_ready_after", p_line_ready, 1);

    // JAL +0x10 from 0xFFFFFFFC wraps to 0x0000000C
    clear_logs();
    offer_line(32'hFFFF_FFF0, NOP, NOP, NOP, enc_j(21'h000010));
    wait_idle("wrap");
    check_q("wrap", q0, 1, {1'b1, 32'h0000_0000}, '0, '0, '0);

    // Flush during slot 1 with one entry queued
    clear_logs();
    pf_ready = 1'b0;
    offer_line(32'h9000, enc_b(3'b000, 13'h0100), enc_b(3'b001, 13'h01FC),
               enc_b(3'b101, 13'h02F8), enc_b(3'b110, 13'h03F4));
    step(1);
    check_eq("flush.pre_valid", p_pf_valid, 1);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    check_eq("flush.pf_valid", p_pf_valid, 0);
    check_eq("flush.line_ready", p_line_ready, 1);
    check_eq("flush.busy", p_busy, 0);
    pf_ready = 1'b1;
    step(8);
    check_q("flush.after", q0, 0, '0, '0, '0, '0);

    // Last-pushed (0x9100) was dropped by flush, so it is requested again
    clear_logs();
    offer_line(32'hA000, enc_b(3'b000, 13'h1100), NOP, NOP, NOP);
    wait_idle("postflush");
    check_q("postflush", q0, 1, {1'b0, 32'h9100}, '0, '0, '0);
    check_q("postflush_bw", q1, 1, {1'b0, 32'h9100}, '0, '0, '0);

    // Asynchronous reset mid-scan
    clear_logs();
    pf_ready = 1'b0;
    offer_line(32'hB000, enc_b(3'b000, 13'h0100), enc_b(3'b001, 13'h01FC),
               enc_b(3'b101, 13'h02F8), enc_b(3'b110, 13'h03F4));
    step(1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst.pf_valid", p_pf_valid, 0);
    check_eq("arst.line_ready", p_line_ready, 1);
    check_eq("arst.busy", p_busy, 0);
    step(2);
    rst_n = 1'b1;
    pf_ready = 1'b1;
    step(8);
    check_q("arst.after", q0, 0, '0, '0, '0, '0);
    check_eq("arst.busy_after", p_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
